// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: Y86-64 fetch-stage PC sequencer.
// Predicts next PC, waits on ret, redirects on mispredict, freezes on halt/error.
module fetch_pc_controller #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       f_icode,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    input  logic             f_instr_valid,
    input  logic             f_imem_error,
    input  logic             stall,
    input  logic             mis_valid,
    input  logic [63:0]      mis_pc,
    input  logic             ret_valid,
    input  logic [63:0]      ret_pc,
    output logic [63:0]      pc,
    output logic             f_bubble,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_ADR = 2'd2;
    localparam logic [1:0] ST_INS = 2'd3;

    typedef enum logic [1:0] {
        RUN,
        WAIT_RET,
        HALTED
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [63:0]      pc_q;
    logic [63:0]      pc_d;
    logic [1:0]       status_q;
    logic [1:0]       status_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic dec_ok;
    logic dec_adr;
    logic dec_ins;
    logic dec_hlt;
    logic dec_jmp;
    logic dec_ret;
    logic dec_seq;

    // Mutually exclusive fetch classes; address error outranks illegal instr.
    always_comb begin
        dec_ok  = f_instr_valid & ~f_imem_error;
        dec_adr = f_imem_error;
        dec_ins = ~f_imem_error & ~f_instr_valid;
        dec_hlt = dec_ok & (f_icode == I_HALT);
        dec_jmp = dec_ok & ((f_icode == I_JXX) | (f_icode == I_CALL));
        dec_ret = dec_ok & (f_icode == I_RET);
        dec_seq = dec_ok & ~dec_hlt & ~dec_jmp & ~dec_ret;
    end

    assign f_bubble = (state_q != RUN) | stall | mis_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        if (mis_valid) begin
            pc_d     = mis_pc;
            state_d  = RUN;
            status_d = ST_AOK;
        end else if (!stall) begin
            unique case (state_q)
                RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    unique case (1'b1)
                        dec_adr: begin
                            status_d = ST_ADR;
                            state_d  = HALTED;
                        end
                        dec_ins: begin
                            status_d = ST_INS;
                            state_d  = HALTED;
                        end
                        dec_hlt: begin
                            status_d = ST_HLT;
                            state_d  = HALTED;
                        end
                        dec_jmp: pc_d    = f_valC;
                        dec_ret: state_d = WAIT_RET;
                        dec_seq: pc_d    = f_valP;
                        default: ;
                    endcase
                end
                WAIT_RET: begin
                    if (ret_valid) begin
                        pc_d    = ret_pc;
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            status_q <= ST_AOK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign status      = status_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb_fetch_pc_controller: directed + random checks of fetch_pc_controller
// against a behavioural model of the fetch sequencing rules.
module tb_fetch_pc_controller;

    localparam logic [63:0] RPC = 64'h4;
    localparam int          CW  = 4;

    logic          clk;
    logic          reset;
    logic [3:0]    f_icode;
    logic [63:0]   f_valC;
    logic [63:0]   f_valP;
    logic          f_instr_valid;
    logic          f_imem_error;
    logic          stall;
    logic          mis_valid;
    logic [63:0]   mis_pc;
    logic          ret_valid;
    logic [63:0]   ret_pc;
    logic [63:0]   pc;
    logic          f_bubble;
    logic [1:0]    status;
    logic [CW-1:0] fetch_count;

    fetch_pc_controller #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error),
        .stall(stall), .mis_valid(mis_valid), .mis_pc(mis_pc),
        .ret_valid(ret_valid), .ret_pc(ret_pc),
        .pc(pc), .f_bubble(f_bubble), .status(status),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // model: mode 0 = fetching, 1 = waiting on return, 2 = frozen
    logic [63:0]   m_pc;
    int            m_mode;
    logic [1:0]    m_status;
    logic [CW-1:0] m_count;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_mode = 0;
        m_status = 2'd0;
        m_count = '0;
    endtask

    task automatic model_update();
        if (reset) begin
            model_reset();
        end else if (mis_valid) begin
            m_pc = mis_pc;
            m_mode = 0;
            m_status = 2'd0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_mode == 0) begin
            m_count = m_count + 1'b1;
            if (f_imem_error) begin
                m_status = 2'd2;
                m_mode = 2;
            end else if (!f_instr_valid) begin
                m_status = 2'd3;
                m_mode = 2;
            end else if (f_icode == 4'd0) begin
                m_status = 2'd1;
                m_mode = 2;
            end else if (f_icode == 4'd7 || f_icode == 4'd8) begin
                m_pc = f_valC;
            end else if (f_icode == 4'd9) begin
                m_mode = 1;
            end else begin
                m_pc = f_valP;
            end
        end else if (m_mode == 1 && ret_valid) begin
            m_pc = ret_pc;
            m_mode = 0;
        end
    endtask

    // compare against the model, then advance one clock
    task automatic step();
        logic exp_bub;
        #1;
        exp_bub = (m_mode != 0) || stall || mis_valid;
        chk("pc", pc, m_pc);
        chk("status", 64'(status), 64'(m_status));
        chk("fetch_count", 64'(fetch_count), 64'(m_count));
        chk("f_bubble", 64'(f_bubble), 64'(exp_bub));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vc,
                         input logic [63:0] vp);
        f_icode = ic;
        f_valC = vc;
        f_valP = vp;
        f_instr_valid = 1'b1;
        f_imem_error = 1'b0;
        stall = 1'b0;
        mis_valid = 1'b0;
        ret_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        fetch(4'd1, 64'h0, 64'h0);
        mis_valid = 1'b1;
        mis_pc = target;
        step();
    endtask

    logic [CW-1:0] c0;

    initial begin
        fetch(4'd1, 64'h0, 64'h0);
        mis_pc = 64'h0;
        ret_pc = 64'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // reset, irmovq at 0x4
        fetch(4'd3, 64'h0, 64'hE);
        #1;
        chk("lit_reset_pc", pc, 64'h4);
        chk("lit_reset_bubble", 64'(f_bubble), 64'd0);
        chk("lit_reset_count", 64'(fetch_count), 64'd0);
        chk("lit_reset_status", 64'(status), 64'd0);
        step();
        fetch(4'd3, 64'h0, 64'h20);
        #1;
        chk("lit_seq_pc", pc, 64'hE);
        chk("lit_seq_count", 64'(fetch_count), 64'd1);
        step();

        // predicted-taken jXX then mispredict
        fetch(4'd7, 64'h100, 64'h29);
        #1;
        chk("lit_jxx_at", pc, 64'h20);
        step();
        fetch(4'd3, 64'h0, 64'h10A);
        mis_valid = 1'b1;
        mis_pc = 64'h29;
        #1;
        chk("lit_jxx_target", pc, 64'h100);
        chk("lit_mis_bubble", 64'(f_bubble), 64'd1);
        c0 = fetch_count;
        step();
        fetch(4'd3, 64'h0, 64'h40);
        #1;
        chk("lit_mis_pc", pc, 64'h29);
        chk("lit_mis_nocount", 64'(fetch_count), 64'(c0));
        step();

        // ret waits for its target
        fetch(4'd9, 64'h0, 64'h41);
        step();
        for (int i = 0; i < 3; i++) begin
            fetch(4'd3, 64'h0, 64'h99);
            #1;
            chk("lit_ret_bubble", 64'(f_bubble), 64'd1);
            chk("lit_ret_pc", pc, 64'h40);
            step();
        end
        ret_valid = 1'b1;
        ret_pc = 64'h88;
        step();
        fetch(4'd3, 64'h0, 64'h50);
        #1;
        chk("lit_ret_resume", pc, 64'h88);
        chk("lit_ret_resume_bub", 64'(f_bubble), 64'd0);
        step();

        // halt freezes until a redirect
        fetch(4'd0, 64'h0, 64'h51);
        step();
        for (int i = 0; i < 4; i++) begin
            fetch(4'd3, 64'h0, 64'h77);
            ret_valid = 1'b1;
            ret_pc = 64'h1234;
            #1;
            chk("lit_hlt_status", 64'(status), 64'd1);
            chk("lit_hlt_pc", pc, 64'h50);
            step();
        end
        redirect(64'h60);
        fetch(4'd3, 64'h0, 64'hFFFF);
        #1;
        chk("lit_unhalt_status", 64'(status), 64'd0);
        chk("lit_unhalt_pc", pc, 64'h60);
        chk("lit_unhalt_bubble", 64'(f_bubble), 64'd0);
        step();

        // address error outranks invalid instruction
        fetch(4'd3, 64'h0, 64'h0);
        f_imem_error = 1'b1;
        f_instr_valid = 1'b0;
        step();
        #1;
        chk("lit_adr_status", 64'(status), 64'd2);
        chk("lit_adr_pc", pc, 64'hFFFF);
        redirect(64'h30);

        // stall holds, then reset out of WAIT_RET
        c0 = m_count;
        for (int i = 0; i < 2; i++) begin
            fetch(4'd3, 64'h0, 64'h38);
            stall = 1'b1;
            ret_valid = 1'b1;
            #1;
            chk("lit_stall_pc", pc, 64'h30);
            chk("lit_stall_count", 64'(fetch_count), 64'(c0));
            step();
        end
        fetch(4'd3, 64'h0, 64'h38);
        step();
        fetch(4'd9, 64'h0, 64'h39);
        step();
        fetch(4'd3, 64'h0, 64'h40);
        reset = 1'b1;
        step();
        fetch(4'd3, 64'h0, 64'hE);
        #1;
        chk("lit_rst_pc", pc, RPC);
        chk("lit_rst_count", 64'(fetch_count), 64'd0);
        chk("lit_rst_bubble", 64'(f_bubble), 64'd0);
        step();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            mis_valid = ($urandom_range(0, 19) == 0);
            mis_pc = {$urandom, $urandom};
            stall = ($urandom_range(0, 6) == 0);
            ret_valid = ($urandom_range(0, 2) == 0);
            ret_pc = {$urandom, $urandom};
            f_imem_error = ($urandom_range(0, 29) == 0);
            f_instr_valid = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 39) == 0) f_icode = 4'd0;
            else f_icode = 4'($urandom_range(1, 11));
            f_valC = {$urandom, $urandom};
            f_valP = m_pc + 64'($urandom_range(1, 10));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
